// File: rtl/mmio_fabric_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmio_fabric_pkg
// Description : Shared definitions for the MMIO fabric: FSM state encoding,
//               default error read data and peripheral slot numbers.
// Revision    : 1.0 - initial release
// ============================================================================
package mmio_fabric_pkg;

    // Fabric transaction state; encoding is fixed so it can be observed on
    // debug taps with a stable meaning.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Read data returned when an access terminates with an error.
    localparam logic [15:0] c_ERR_DATA_DEFAULT = 16'hDEAD;

    // Peripheral slot numbers inherited from the legacy one-hot MEM mux.
    localparam int c_SLV_STATUS    = 0;
    localparam int c_SLV_ADDRSTACK = 1;
    localparam int c_SLV_USERSTACK = 2;
    localparam int c_SLV_UART      = 3;
    localparam int c_SLV_GPIO      = 4;
    localparam int c_SLV_GPIODIR   = 5;
    localparam int c_SLV_MEM       = 6;

endpackage : mmio_fabric_pkg
`default_nettype wire

// File: rtl/mmio_decode.sv
`default_nettype none
// ============================================================================
// Module      : mmio_decode
// Description : Combinational slave decode. Takes the slave-select field of
//               the master address, range-checks it against the number of
//               attached slaves and produces a one-hot select (all zero when
//               the field points at an unpopulated slot).
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_decode #(
    parameter int SEL_BITS = 3,
    parameter int NSLV     = 7
) (
    input  logic [SEL_BITS-1:0] i_field,
    output logic                o_valid,
    output logic [NSLV-1:0]     o_onehot
);

    // Widen by one bit so NSLV == 2**SEL_BITS compares correctly.
    assign o_valid = ({1'b0, i_field} < (SEL_BITS+1)'(NSLV));

    generate
        for (genvar gi = 0; gi < NSLV; gi++) begin : g_onehot
            assign o_onehot[gi] = o_valid && (i_field == SEL_BITS'(gi));
        end
    endgenerate

endmodule : mmio_decode
`default_nettype wire

// File: rtl/mmio_fabric.sv
`default_nettype none
// ============================================================================
// Module      : mmio_fabric
// Description : Registered request/acknowledge MMIO interconnect, one master
//               to NSLV peripherals. Slaves may stretch an access with wait
//               states; unmapped addresses end in a decode error and silent
//               slaves end in a timeout, so the bus can never hang.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_fabric
    import mmio_fabric_pkg::*;
#(
    parameter int             DW       = 16,
    parameter int             AW       = 16,
    parameter int             SEL_BITS = 3,
    parameter int             NSLV     = 7,
    parameter int             TIMEOUT  = 16,
    parameter logic [DW-1:0]  ERR_DATA = DW'(c_ERR_DATA_DEFAULT)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   m_req,
    input  logic                   m_write,
    input  logic [AW-1:0]          m_addr,
    input  logic [DW-1:0]          m_wdata,
    output logic                   m_busy,
    output logic                   m_done,
    output logic                   m_err,
    output logic [DW-1:0]          m_rdata,
    output logic [NSLV-1:0]        s_sel,
    output logic                   s_write,
    output logic [AW-SEL_BITS-1:0] s_addr,
    output logic [DW-1:0]          s_wdata,
    input  logic [NSLV*DW-1:0]     s_rdata,
    input  logic [NSLV-1:0]        s_ack,
    output logic [7:0]             err_count,
    output logic [AW-1:0]          err_addr
);

    localparam int            OW         = AW - SEL_BITS;
    localparam int            CW         = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] c_TMO_LAST = CW'(TIMEOUT - 1);

    state_t          r_state;
    state_t          w_next;
    logic [NSLV-1:0] r_sel;
    logic            r_write;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [CW-1:0]   r_cnt;
    logic            r_done;
    logic            r_err;
    logic [DW-1:0]   r_rdata;
    logic [7:0]      r_err_count;
    logic [AW-1:0]   r_err_addr;

    logic            w_valid;
    logic [NSLV-1:0] w_onehot;
    logic            w_ack;
    logic            w_timeout;
    logic [DW-1:0]   w_slv_rdata;
    logic            w_finish;
    logic            w_fin_err;
    logic            w_fin_write;
    logic [DW-1:0]   w_fin_rdata;
    logic [AW-1:0]   w_fin_addr;

    mmio_decode #(
        .SEL_BITS (SEL_BITS),
        .NSLV     (NSLV)
    ) u_decode (
        .i_field  (m_addr[AW-1 -: SEL_BITS]),
        .o_valid  (w_valid),
        .o_onehot (w_onehot)
    );

    // Only the ack of the currently selected slave can end an access.
    assign w_ack     = |(s_ack & r_sel);
    assign w_timeout = (r_cnt == c_TMO_LAST);

    // Read-data mux driven by the registered one-hot select.
    always_comb begin
        w_slv_rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (r_sel[i]) begin
                w_slv_rdata = w_slv_rdata | s_rdata[i*DW +: DW];
            end
        end
    end

    // Next state plus the completion result that is loaded on entry to RESP.
    always_comb begin
        w_next      = r_state;
        w_finish    = 1'b0;
        w_fin_err   = 1'b0;
        w_fin_write = r_write;
        w_fin_addr  = r_addr;
        w_fin_rdata = '0;
        unique case (r_state)
            IDLE: begin
                w_fin_write = m_write;
                w_fin_addr  = m_addr;
                if (m_req) begin
                    if (w_valid) begin
                        w_next = ACCESS;
                    end else begin
                        w_next    = RESP;
                        w_finish  = 1'b1;
                        w_fin_err = 1'b1;
                    end
                end
            end
            ACCESS: begin
                // An ack on the timeout cycle still counts as success.
                if (w_ack || w_timeout) begin
                    w_next    = RESP;
                    w_finish  = 1'b1;
                    w_fin_err = !w_ack;
                end
            end
            RESP: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
        if (!w_fin_write) begin
            w_fin_rdata = w_fin_err ? ERR_DATA : w_slv_rdata;
        end
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request capture, slave-side registers, wait counter and master response.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sel       <= '0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cnt       <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_err_count <= '0;
            r_err_addr  <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE && m_req) begin
                r_write <= m_write;
                r_addr  <= m_addr;
                r_wdata <= m_wdata;
                r_cnt   <= '0;
                r_sel   <= w_onehot;
            end else if (r_state == ACCESS) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_finish) begin
                r_sel   <= '0;
                r_done  <= 1'b1;
                r_err   <= w_fin_err;
                r_rdata <= w_fin_rdata;
                if (w_fin_err) begin
                    r_err_addr <= w_fin_addr;
                    if (r_err_count != 8'hFF) begin
                        r_err_count <= r_err_count + 8'd1;
                    end
                end
            end
        end
    end

    assign m_busy    = (r_state != IDLE);
    assign m_done    = r_done;
    assign m_err     = r_err;
    assign m_rdata   = r_rdata;
    assign s_sel     = r_sel;
    assign s_write   = r_write;
    assign s_addr    = r_addr[OW-1:0];
    assign s_wdata   = r_wdata;
    assign err_count = r_err_count;
    assign err_addr  = r_err_addr;

endmodule : mmio_fabric
`default_nettype wire

// File: doc/mmio_fabric.md
Name: mmio_fabric

Overview:
Parametrised memory-mapped I/O interconnect: the next generation of the console's one-hot MEM peripheral mux (status, uart, stacks, gpio, gpiodir). It replaces that combinational select with a registered request/acknowledge fabric: one master (the RAM/memory controller) and NSLV peripherals. Peripherals may insert wait states; unresponsive or unmapped accesses terminate by timeout or decode error instead of hanging the bus. It sits between the memory controller's MMIO window and the peripheral blocks.

Parameters:
DW, 16, data width.
AW, 16, master address width.
SEL_BITS, 3, top address bits selecting the slave; slave index = m_addr[AW-1 -: SEL_BITS].
NSLV, 7, number of attached slaves; must satisfy NSLV <= 2**SEL_BITS.
TIMEOUT, 16, ACCESS cycles without ack before an error terminates the access; must be >= 1.
ERR_DATA, 16'hDEAD, read data returned on an error.

Ports:
CLK  input  1  system clock.
RST  input  1  reset, asynchronous, active-high.
m_req  input  1  master request, sampled only in IDLE.
m_write  input  1  1 = write, 0 = read.
m_addr  input  AW  master address.
m_wdata  input  DW  write data.
m_busy  output  1  high whenever state != IDLE.
m_done  output  1  one-cycle completion pulse.
m_err  output  1  valid with m_done: decode error or timeout.
m_rdata  output  DW  read data, valid with m_done.
s_sel  output  NSLV  one-hot slave select.
s_write  output  1  registered write flag.
s_addr  output  AW-SEL_BITS  registered offset, m_addr[AW-SEL_BITS-1:0].
s_wdata  output  DW  registered write data.
s_rdata  input  NSLV*DW  flattened slave read data; slave i occupies bits [i*DW +: DW].
s_ack  input  NSLV  per-slave acknowledge.
err_count  output  8  saturating count of errored accesses.
err_addr  output  AW  address of the most recent errored access.

Behaviour:
- Reset (asynchronous): state IDLE; s_sel=0; m_busy=0; m_done=0; m_err=0; m_rdata=0; s_write=0; s_addr=0; s_wdata=0; err_count=0; err_addr=0. A reset during ACCESS drops s_sel immediately and the transaction is lost.
- FSM states: IDLE, ACCESS, RESP.
- IDLE with m_req=1:
  - Capture m_write, m_addr and m_wdata.
  - If the decoded index is < NSLV: go to ACCESS and drive s_sel[index]=1 from the next cycle.
  - If the decoded index is >= NSLV: go directly to RESP with err=1; s_sel stays 0.
- IDLE with m_req=0: stay in IDLE; outputs hold, except m_done=0.
- ACCESS:
  - s_sel, s_write, s_addr and s_wdata are held stable; the wait counter increments each cycle.
  - s_ack[index]=1: latch s_rdata of the selected slave (0 for writes) and go to RESP with err=0.
  - Acks from non-selected slaves are ignored.
  - Counter reaches TIMEOUT-1 with no ack: go to RESP with err=1 and rdata=ERR_DATA (0 for writes).
  - Ack in the same cycle as the timeout: the ack wins and err=0.
- RESP: m_done=1 for exactly one cycle with m_rdata and m_err valid; s_sel=0; next state IDLE.
  - m_req is not sampled in RESP, so back-to-back accesses occur every 3 cycles minimum.
- Latency, zero-wait slave: request sampled at edge 0; s_sel high in cycle 1; ack in cycle 1; m_done in cycle 2.
- m_rdata holds its value until the next m_done.
- m_req while m_busy=1 is ignored; there is no queueing.
- Error bookkeeping: on every errored completion, err_count increments, saturating at 255, and err_addr is loaded with the captured address.
- Arithmetic: the wait counter is clog2(TIMEOUT)+1 bits wide and cleared on entry to ACCESS.

Decomposition:
- Shared package/header (mmio_defs.vh): FSM state encodings (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2), default ERR_DATA, and slave index constants (STATUS=0, ADDRSTACK=1, USERSTACK=2, UART=3, GPIO=4, GPIODIR=5, MEM=6).
- One sub-module, mmio_decode: combinational index extraction, range check and one-hot generation, parametrised by SEL_BITS and NSLV. Everything else stays in mmio_fabric.

Test Plan:
- Zero-wait read: slave 4 returns 16'h00A5 with ack held high; read at m_addr=16'h8003 -> s_sel=7'b0010000 and s_addr=13'h0003 in cycle 1; m_done in cycle 2 with m_rdata=16'h00A5 and m_err=0.
- Wait-state write: slave 2 acks after 5 cycles; write 16'h1234 to 16'h4010 -> s_wdata=16'h1234 stable for all 5 cycles; m_done follows 1 cycle after the ack; m_busy is high throughout.
- Timeout: slave 1 never acks, TIMEOUT=16 -> s_sel drops after 16 ACCESS cycles; m_done with m_err=1, m_rdata=16'hDEAD, err_count=1, err_addr=address.
- Decode error: m_addr=16'hE000 (index 7, NSLV=7) -> s_sel never asserts; m_done 1 cycle after sampling, m_err=1.
- Simultaneous events: ack on the exact timeout cycle -> m_err=0 with valid data. Ack from a non-selected slave -> ignored. m_req held continuously -> accesses issued at most every 3 cycles.
- Reset mid-access: assert RST during ACCESS -> s_sel=0 and m_busy=0 asynchronously; err_count=0; no m_done pulse. The next request after deassertion completes normally.
